// File: rtl/npcnn_pkg.sv
// Shared definitions for the npcnn convolution core and its post-processing stages.
// Holds the frame state encoding, the default layer geometry and a constant
// log2 helper for sizing counters.
package npcnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int OS_DEFAULT    = 4;
    localparam int POOL_DEFAULT  = 2;
    localparam int IN_W_DEFAULT  = 20;
    localparam int OUT_W_DEFAULT = 8;
    localparam int SHIFT_DEFAULT = 8;

    // Ceiling log2. Returns 0 for values of 0 or 1, so callers clamp to 1 bit.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/npcnn_requant.sv
// Requantizer: non-negative (ReLU'd) value -> right shift -> saturate to an
// unsigned OUT_W-bit activation. Purely combinational.
// Build option: define NPPOOL_ROUND_EN to add round-half-up before the shift.
module npcnn_requant
    import npcnn_pkg::*;
#(
    parameter int IN_W  = IN_W_DEFAULT,
    parameter int OUT_W = OUT_W_DEFAULT,
    parameter int SHIFT = SHIFT_DEFAULT
) (
    input  logic [IN_W-2:0]  din,
    output logic [OUT_W-1:0] dout
);

    localparam logic [IN_W-1:0] LIMIT = {{(IN_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
`ifdef NPPOOL_ROUND_EN
    localparam logic [IN_W-1:0] HALF = IN_W'(1) << (SHIFT - 1);
`endif

    logic [IN_W-1:0] biased;
    logic [IN_W-1:0] shifted;

    // The input is only IN_W-1 bits wide, so the rounding add on IN_W bits cannot overflow.
    always_comb begin
`ifdef NPPOOL_ROUND_EN
        biased = {1'b0, din} + HALF;
`else
        biased = {1'b0, din};
`endif
        shifted = biased >> SHIFT;
        dout    = (shifted > LIMIT) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
    end

endmodule

// File: rtl/npcnn_relu_pool.sv
// ReLU + non-overlapping POOL x POOL max pooling + requantization of one
// OS x OS raster-ordered convolution map. One registered output strobe per
// completed window, one cycle after the window's last beat.
// Build option: NPPOOL_ROUND_EN selects round-half-up in the requantizer.
module npcnn_relu_pool
    import npcnn_pkg::*;
#(
    parameter int OS    = OS_DEFAULT,
    parameter int POOL  = POOL_DEFAULT,
    parameter int IN_W  = IN_W_DEFAULT,
    parameter int OUT_W = OUT_W_DEFAULT,
    parameter int SHIFT = SHIFT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int NB   = OS / POOL;
    localparam int SPAN = NB * POOL;
    localparam int CW   = (clog2(OS) > 0) ? clog2(OS) : 1;
    localparam int IW   = (clog2(NB) > 0) ? clog2(NB) : 1;
    localparam int RW   = IN_W - 1;

    generate
        if (OS < POOL) begin : g_bad_geometry
            $error("npcnn_relu_pool: OS must be >= POOL");
        end
        if (SHIFT < 1 || SHIFT >= IN_W) begin : g_bad_shift
            $error("npcnn_relu_pool: SHIFT must satisfy 1 <= SHIFT < IN_W");
        end
        if (OUT_W >= IN_W) begin : g_bad_width
            $error("npcnn_relu_pool: OUT_W must be narrower than IN_W");
        end
    endgenerate

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [RW-1:0] rowbuf [NB];

    int            col_i;
    int            row_i;
    logic          accept;
    logic          start;
    logic          in_range;
    logic          win_first;
    logic          win_last;
    logic          frame_last;
    logic [IW-1:0] idx;
    logic [RW-1:0] relu;
    logic [RW-1:0] win_max;
    logic [OUT_W-1:0] quant;

    assign col_i  = int'(col);
    assign row_i  = int'(row);
    assign accept = (state == RUN) && in_valid;
    assign start  = (state != RUN) && go;
    assign busy   = (state == RUN);

    // Window decode for the current beat and the running max including it.
    always_comb begin
        relu       = in_data[IN_W-1] ? '0 : in_data[RW-1:0];
        in_range   = (col_i < SPAN) && (row_i < SPAN);
        win_first  = ((col_i % POOL) == 0) && ((row_i % POOL) == 0);
        win_last   = in_range && ((col_i % POOL) == POOL - 1) && ((row_i % POOL) == POOL - 1);
        frame_last = win_last && ((col_i / POOL) == NB - 1) && ((row_i / POOL) == NB - 1);
        idx        = in_range ? IW'(col_i / POOL) : '0;
        win_max    = (win_first || (relu > rowbuf[idx])) ? relu : rowbuf[idx];
    end

    npcnn_requant #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .din  (win_max),
        .dout (quant)
    );

    // Frame state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame sequencing: the beat completing the last window ends the frame.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go) state_next = RUN;
            RUN:     if (accept && frame_last) state_next = DONE;
            DONE:    if (go) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Raster position of the next beat; restarts on every accepted go.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
        end else if (start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == CW'(OS - 1)) begin
                col <= '0;
                row <= (row == CW'(OS - 1)) ? '0 : row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Per-column-window partial maxima; beats outside the pooled area are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NB; i++) begin
                rowbuf[i] <= '0;
            end
        end else if (accept && in_range) begin
            rowbuf[idx] <= win_max;
        end
    end

    // Registered output strobe, frame-end flag and done level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= accept && win_last;
            out_last  <= accept && frame_last;
            if (accept && win_last) begin
                out_data <= quant;
            end
            done <= (state == DONE) && !go;
        end
    end

endmodule

// File: doc/npcnn_relu_pool.md
Name: npcnn_relu_pool

Overview:
- Post-processing stage directly downstream of the npcnn convolution core.
- Consumes the core's raster-ordered stream of signed 20-bit convolution results for one OS x OS output map.
- Applies ReLU, then non-overlapping POOL x POOL max pooling, then requantizes each pooled value to an unsigned 8-bit activation for the next layer's input buffer.
- Emits one pooled pixel per window plus end-of-frame status.

Parameters:
- OS, 4, convolution output map side (conv core configured 6/3/1/0 gives 4).
- POOL, 2, pooling window side and stride.
- IN_W, 20, input sample width (signed two's complement).
- OUT_W, 8, output activation width (unsigned).
- SHIFT, 8, requantization right-shift amount; 1 <= SHIFT < IN_W.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  start-of-frame; sampled only in IDLE or DONE.
- in_data  in  IN_W  signed convolution result.
- in_valid  in  1  in_data valid this cycle; gaps allowed.
- out_data  out  OUT_W  pooled, requantized activation.
- out_valid  out  1  single-cycle strobe per pooled pixel.
- out_last  out  1  high with out_valid on the final pooled pixel of the frame.
- busy  out  1  high in RUN.
- done  out  1  level; high from the cycle after the last pooled pixel until the next accepted go.

Behaviour:
- Reset (reset=0, async): state=IDLE; col, row and row buffer cleared; out_data=0; out_valid=0; out_last=0; busy=0; done=0.
- States:
  - IDLE: go=1 -> RUN (counters cleared).
  - RUN: in_valid beats accepted.
  - After the last window is emitted -> DONE.
  - DONE: done=1; go=1 -> RUN, clears done the same edge.
- go in RUN is ignored. in_valid in IDLE or DONE is ignored (no state change).
- Counters: col 0..OS-1, row 0..OS-1. col advances per accepted beat; at col=OS-1 it wraps to 0 and row increments.
- ReLU: r = (in_data < 0) ? 0 : in_data, unsigned on IN_W-1 bits.
- Row buffer: OS/POOL entries of IN_W-1 bits, indexed by col/POOL.
  - Window first element (row%POOL==0 and col%POOL==0): entry := r.
  - Otherwise: entry := max(entry, r).
- Boundary: if OS is not a multiple of POOL, beats with col >= (OS/POOL)*POOL or row >= (OS/POOL)*POOL are consumed but discarded (floor pooling). Require OS >= POOL, enforced by an elaboration-time check.
- Emit: on the beat with row%POOL==POOL-1 and col%POOL==POOL-1, the final max m = max(entry, r) is computed combinationally.
  - Next cycle: out_valid=1 and out_data = sat(m >> SHIFT), saturating to 2^OUT_W-1.
  - Latency: 1 cycle from the last window beat. Otherwise out_valid=0; out_data holds its last value.
- out_last=1 with the emission of window ((OS/POOL)-1, (OS/POOL)-1). Same edge: state -> DONE. done=1 the following cycle.
- Pooled output order is raster; (OS/POOL)^2 outputs per frame (4 at defaults).
- Back-to-back windows with no in_valid gaps give at most one out_valid per POOL input beats. No backpressure; the consumer must always accept.
- reset mid-frame aborts immediately. Partial window content is lost and no output is produced.

Optional Feature:
- Macro NPPOOL_ROUND_EN.
- Defined: round-half-up before the shift, out = sat((m + 2^(SHIFT-1)) >> SHIFT). The sum is computed on IN_W bits so there is no overflow before saturation.
- Undefined: plain truncating shift. Interface and latency are identical in both builds.

Decomposition:
- Shared package npcnn_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - default OS/POOL/IN_W/OUT_W/SHIFT constants, shared with the conv core;
  - function clog2 for counter widths.
- One natural sub-module, npcnn_requant: combinational ReLU'd value in -> shift, optional round, saturate -> OUT_W out. It is reused later for other layer outputs.

Test Plan:
- Defaults, go, then 16 contiguous beats in_data = 256*i (i=0..15) -> out_data 5, 7, 13, 15 on four out_valid strobes, each 1 cycle after beats 5, 7, 13, 15; out_last on the 4th; done=1 the next cycle.
- All 16 beats negative (-1000) -> four outputs of 0; done asserts.
- Window containing 20'h7FFFF -> that output saturates to 255; others unaffected.
- Same data as case 1 with random 0-3 cycle in_valid gaps -> identical values and order; no extra strobes; in_valid pulses while in DONE are ignored.
- reset low for 1 cycle after beat 9, then go plus a full frame -> no output before the restart; fresh frame yields the correct 4 values.
- Beat value 384 as window max -> out 1 without NPPOOL_ROUND_EN, 2 with it; value 383 -> 1 in both builds.
